// File: rtl/poly_byte_loader.sv
// Unpacks a ByteDecode12 byte stream into coefficient pairs and writes each
// pair into the dual-port polynomial RAM through both write ports at once.
module poly_byte_loader #(
    parameter int DEPTH = 256,
    parameter int Q     = 3329
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        w1_en,
    output logic [15:0] w1_addr,
    output logic [15:0] w1_data,
    output logic        w2_en,
    output logic [15:0] w2_addr,
    output logic [15:0] w2_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int PAIRS = DEPTH / 2;
    localparam int KW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(PAIRS - 1);
    localparam logic [12:0]   Q_LIM  = 13'(Q);

    typedef enum logic [2:0] {
        S_IDLE,
        S_B0,
        S_B1,
        S_B2,
        S_FLUSH
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [7:0]    b0_q, b0_d;
    logic [7:0]    b1_q, b1_d;
    logic          byte_ready_q, byte_ready_d;
    logic          w1_en_q, w1_en_d;
    logic          w2_en_q, w2_en_d;
    logic [15:0]   w1_addr_q, w1_addr_d;
    logic [15:0]   w2_addr_q, w2_addr_d;
    logic [15:0]   w1_data_q, w1_data_d;
    logic [15:0]   w2_data_q, w2_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          xfer;
    logic [11:0]   c0;
    logic [11:0]   c1;

    assign xfer = byte_valid && byte_ready_q;

    // b2 is never stored: the pair is decoded straight off the bus on its transfer edge.
    assign c0 = {b1_q[3:0], b0_q};
    assign c1 = {byte_in, b1_q[7:4]};

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        b0_d      = b0_q;
        b1_d      = b1_q;
        w1_en_d   = 1'b0;
        w2_en_d   = 1'b0;
        w1_addr_d = w1_addr_q;
        w2_addr_d = w2_addr_q;
        w1_data_d = w1_data_q;
        w2_data_d = w2_data_q;
        done_d    = 1'b0;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d     = '0;
                    err_d   = 1'b0;
                    state_d = S_B0;
                end
            end
            S_B0: begin
                if (xfer) begin
                    b0_d    = byte_in;
                    state_d = S_B1;
                end
            end
            S_B1: begin
                if (xfer) begin
                    b1_d    = byte_in;
                    state_d = S_B2;
                end
            end
            S_B2: begin
                if (xfer) begin
                    w1_en_d   = 1'b1;
                    w2_en_d   = 1'b1;
                    w1_data_d = {4'h0, c0};
                    w2_data_d = {4'h0, c1};
                    w1_addr_d = 16'({k_q, 1'b0});
                    w2_addr_d = 16'({k_q, 1'b1});
                    if (({1'b0, c0} >= Q_LIM) || ({1'b0, c1} >= Q_LIM)) begin
                        err_d = 1'b1;
                    end
                    if (k_q < K_LAST) begin
                        k_d     = k_q + KW'(1);
                        state_d = S_B0;
                    end else begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake/status flags track the state being entered so they stay registered.
        byte_ready_d = (state_d == S_B0) || (state_d == S_B1) || (state_d == S_B2);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            b0_q         <= '0;
            b1_q         <= '0;
            byte_ready_q <= 1'b0;
            w1_en_q      <= 1'b0;
            w2_en_q      <= 1'b0;
            w1_addr_q    <= '0;
            w2_addr_q    <= '0;
            w1_data_q    <= '0;
            w2_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            b0_q         <= b0_d;
            b1_q         <= b1_d;
            byte_ready_q <= byte_ready_d;
            w1_en_q      <= w1_en_d;
            w2_en_q      <= w2_en_d;
            w1_addr_q    <= w1_addr_d;
            w2_addr_q    <= w2_addr_d;
            w1_data_q    <= w1_data_d;
            w2_data_q    <= w2_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign w1_en      = w1_en_q;
    assign w2_en      = w2_en_q;
    assign w1_addr    = w1_addr_q;
    assign w2_addr    = w2_addr_q;
    assign w1_data    = w1_data_q;
    assign w2_data    = w2_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_poly_byte_loader.sv
// Self-checking bench for poly_byte_loader: a table of single-pair decodes,
// then full loads covering stalls, ignored starts, mid-load reset and re-arm.
module tb_poly_byte_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        w1_en;
    logic [15:0] w1_addr;
    logic [15:0] w1_data;
    logic        w2_en;
    logic [15:0] w2_addr;
    logic [15:0] w2_data;
    logic        busy;
    logic        done;
    logic        err;

    poly_byte_loader #(
        .DEPTH(256),
        .Q    (3329)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .w1_en     (w1_en),
        .w1_addr   (w1_addr),
        .w1_data   (w1_data),
        .w2_en     (w2_en),
        .w2_addr   (w2_addr),
        .w2_data   (w2_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wr1_count = 0;
    int pair_bad = 0;
    int idle_bad = 0;
    int done_count = 0;
    int gen = 0;
    logic [15:0] mem [256];
    int          gen_mem [256];

    // RAM model: commits on the edge that ends the strobe cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (w1_en) begin
            mem[w1_addr[7:0]]     <= w1_data;
            gen_mem[w1_addr[7:0]] <= gen;
            wr1_count             <= wr1_count + 1;
        end
        if (w2_en) begin
            mem[w2_addr[7:0]]     <= w2_data;
            gen_mem[w2_addr[7:0]] <= gen;
        end
        if (done) done_count <= done_count + 1;
    end

    always @(negedge clk) begin
        if (w1_en !== w2_en) pair_bad <= pair_bad + 1;
        if (w1_en && !busy)  idle_bad <= idle_bad + 1;
    end

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [11:0] c0;
        logic [11:0] c1;
        logic        e;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_flags"}, {byte_ready, w1_en, w2_en, busy, done, err}, 0);
        chk({tag, "_addr"}, {w1_addr, w2_addr}, 0);
        chk({tag, "_data"}, {w1_data, w2_data}, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Returns at edge+1 of the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        int   n;
        byte_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        byte_in    = b;
        byte_valid = 1'b1;
        rdy        = 1'b0;
        n          = 0;
        while (!rdy && n < 50) begin
            @(negedge clk);
            rdy = byte_ready;
            @(posedge clk); #1;
            n++;
        end
        byte_valid = 1'b0;
        chk("byte_accept", rdy, 1);
    endtask

    task automatic load_poly(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                             input int max_gap, input bit pulse_b1, input bit pulse_flush,
                             input bit hold_start, input logic [11:0] e0, input logic [11:0] e1,
                             input logic exp_err);
        int first_edge;
        int last_edge;
        int done_edge;
        int wr_base;
        int bad;
        int g;
        bit found;
        gen++;
        wr_base    = wr1_count;
        first_edge = 0;
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        chk("load_busy", busy, 1);
        chk("load_ready", byte_ready, 1);
        chk("err_cleared", err, 0);
        for (int p = 0; p < 128; p++) begin
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            send_byte(p0, g);
            if (p == 0) first_edge = cyc;
            if (p == 0 && pulse_b1) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            send_byte(p1, g);
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            send_byte(p2, g);
            if (p == 1) chk("pair1_strobe", {w1_en, w2_en, w1_addr, w2_addr}, {2'b11, 16'd2, 16'd3});
        end
        last_edge = cyc;
        chk("flush_flags", {busy, byte_ready, w1_en, w2_en, done}, 5'b10110);
        chk("flush_addr", {w1_addr, w2_addr}, {16'd254, 16'd255});
        chk("flush_data", {w1_data, w2_data}, {4'h0, e0, 4'h0, e1});
        chk("flush_err", err, exp_err);
        if (pulse_flush) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        found     = 1'b0;
        done_edge = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (done) begin
                found     = 1'b1;
                done_edge = cyc;
            end
        end
        chk("done_seen", found, 1);
        chk("done_latency", done_edge - last_edge, 1);
        if (max_gap == 0 && !pulse_b1) chk("done_vs_first", done_edge - first_edge, 384);
        chk("done_cycle_flags", {busy, byte_ready, w1_en}, 0);
        chk("done_err", err, exp_err);
        chk("write_pulses", wr1_count - wr_base, 128);
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            if (gen_mem[a] != gen || mem[a] != ((a % 2 == 0) ? {4'h0, e0} : {4'h0, e1})) bad++;
        end
        chk("mem_contents", bad, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, hold_start);
        @(posedge clk); #1;
        $display("load bytes %02h %02h %02h gap<=%0d: done_edge=%0d err=%0b writes=%0d",
                 p0, p1, p2, max_gap, done_edge - first_edge, err, wr1_count - wr_base);
    endtask

    initial begin
        logic [7:0] pat [3];
        int base;

        vt[0] = '{8'h00, 8'h10, 8'h00, 12'h000, 12'h001, 1'b0};
        vt[1] = '{8'h01, 8'h2F, 8'hC3, 12'hF01, 12'hC32, 1'b1};
        vt[2] = '{8'h00, 8'h1D, 8'hD0, 12'hD00, 12'hD01, 1'b1};
        vt[3] = '{8'h00, 8'h0D, 8'hD0, 12'hD00, 12'hD00, 1'b0};
        vt[4] = '{8'h01, 8'h0D, 8'h00, 12'hD01, 12'h000, 1'b1};
        vt[5] = '{8'hFF, 8'hFF, 8'hFF, 12'hFFF, 12'hFFF, 1'b1};
        vt[6] = '{8'h34, 8'h12, 8'hAB, 12'h234, 12'hAB1, 1'b0};
        vt[7] = '{8'h00, 8'hF0, 8'hCF, 12'h000, 12'hCFF, 1'b0};

        #2 rst_n = 1'b0;
        #1 chk_zero("reset_state");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_flags", {busy, byte_ready, done}, 0);
        @(posedge clk); #1;

        // Single-pair decode table: each vector is its own aborted load.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            do_start();
            send_byte(vt[i].b0, 0);
            send_byte(vt[i].b1, 0);
            send_byte(vt[i].b2, 0);
            chk("vec_strobes", {w1_en, w2_en}, 2'b11);
            chk("vec_w1_addr", w1_addr, 0);
            chk("vec_w2_addr", w2_addr, 1);
            chk("vec_c0", w1_data, vt[i].c0);
            chk("vec_c1", w2_data, vt[i].c1);
            chk("vec_err", err, vt[i].e);
            $display("vec %0d bytes %02h %02h %02h: c0=%03h c1=%03h err=%0b",
                     i, vt[i].b0, vt[i].b1, vt[i].b2, w1_data, w2_data, err);
        end
        do_reset();

        // Continuous full load, then a load with random stalls in B0/B1/B2.
        load_poly(8'h00, 8'h10, 8'h00, 0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h001, 1'b0);
        load_poly(8'h01, 8'h2F, 8'hC3, 2, 1'b0, 1'b0, 1'b0, 12'hF01, 12'hC32, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky_idle", err, 1);

        // Starts pulsed in B1 and FLUSH must be ignored; this start also clears err.
        load_poly(8'h00, 8'h10, 8'h00, 0, 1'b1, 1'b1, 1'b0, 12'h000, 12'h001, 1'b0);

        // Asynchronous reset mid-load after 100 bytes.
        pat[0] = 8'h00;
        pat[1] = 8'h10;
        pat[2] = 8'h00;
        do_start();
        for (int i = 0; i < 100; i++) send_byte(pat[i % 3], 0);
        chk("pre_rst_busy", {busy, byte_ready}, 2'b11);
        rst_n = 1'b0;
        #1 chk_zero("async_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        base = done_count;
        repeat (6) begin
            @(posedge clk); #1;
        end
        chk("no_done_after_rst", done_count - base, 0);
        chk("idle_after_rst", busy, 0);
        do_start();
        send_byte(8'h01, 0);
        send_byte(8'h2F, 0);
        send_byte(8'hC3, 0);
        chk("reload_addr", {w1_en, w1_addr, w2_addr}, {1'b1, 16'd0, 16'd1});
        chk("reload_data", {w1_data, w2_data}, {16'h0F01, 16'h0C32});
        $display("reset after 100 bytes: reload pair0 c0=%03h c1=%03h", w1_data, w2_data);
        do_reset();

        // start held high across done re-arms immediately.
        load_poly(8'h34, 8'h12, 8'hAB, 0, 1'b0, 1'b0, 1'b1, 12'h234, 12'hAB1, 1'b0);
        start = 1'b0;
        chk("rearm_ready", byte_ready, 1);
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        chk("rearm_addr", {w1_en, w2_en, w1_addr, w2_addr}, {2'b11, 16'd0, 16'd1});
        $display("rearm load: first pair addr %0d/%0d", w1_addr, w2_addr);
        do_reset();

        chk("strobes_paired", pair_bad, 0);
        chk("no_idle_strobe", idle_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
